// File: rtl/pc_gen_if.sv
// Instruction-fetch bus between pc_gen (master) and the instruction ROM (slave).
// Handshake: rom_en requests the word at rom_addr; rom_ready=1 in the same cycle delivers it.
interface pc_gen_if;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready;

    modport master (output rom_en, output rom_addr, input rom_ready);
    modport slave  (input rom_en, input rom_addr, output rom_ready);
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator / fetch requester with flush and branch redirect buffering.
// Optional macro PC_ALIGN_CHECK_EN adds the if_addr_err fetch-alignment check.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    pc_gen_if.master    rom,
    output logic [31:0] pc,
    output logic        pc_valid,
`ifdef PC_ALIGN_CHECK_EN
    output logic        if_addr_err,
`endif
    output logic        state_dbg
);
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic        load;
    logic [31:0] load_tgt;
    logic        adv;
    logic        halted;

`ifdef PC_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign halted      = err_q;
    assign if_addr_err = err_q;
    assign err_d       = load ? (load_tgt[1:0] != 2'b00) : err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        load         = 1'b0;
        load_tgt     = pc_q;
        // An alignment fault freezes the PC exactly like a permanent wait cycle.
        adv          = rom.rom_ready & ~stall_pc & ~halted;

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (flush) begin
            load         = 1'b1;
            load_tgt     = flush_pc;
            pend_valid_d = 1'b0;
        end else if (adv && branch_flag) begin
            load         = 1'b1;
            load_tgt     = branch_addr;
            pend_valid_d = 1'b0;
        end else if (adv && pend_valid_q) begin
            load         = 1'b1;
            load_tgt     = pend_addr_q;
            pend_valid_d = 1'b0;
        end else if (adv) begin
            pc_d = pc_q + 32'd4;
        end else if (branch_flag) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = branch_addr;
        end

        if (load) begin
`ifdef PC_ALIGN_CHECK_EN
            pc_d = load_tgt;
`else
            pc_d = load_tgt & ~32'h3;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign rom.rom_en   = (state_q == RUN) & ~halted;
    assign rom.rom_addr = pc_q;
    assign pc           = pc_q;
    assign pc_valid     = rom.rom_en & rom.rom_ready;
    assign state_dbg    = (state_q == RUN);
endmodule
